// File: rtl/game_pkg.sv
// Shared definitions for the turn-based board game: FSM state codes, cell,
// winner and player encodings, and default board geometry.
package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT      = 3'd1,
      ST_CHECK     = 3'd2,
      ST_SCAN_ROW  = 3'd3,
      ST_SCAN_COL  = 3'd4,
      ST_DECIDE    = 3'd5,
      ST_GAME_OVER = 3'd6
   } state_e;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_TRI   = 2'b01;
   localparam logic [1:0] CELL_CIR   = 2'b10;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_TRI  = 2'b01;
   localparam logic [1:0] WIN_CIR  = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   localparam logic PLAYER_TRI = 1'b0;
   localparam logic PLAYER_CIR = 1'b1;

   localparam int DEFAULT_GRID    = 10;
   localparam int DEFAULT_WIN_LEN = 4;

   // A player's cell code doubles as its winner code.
   function automatic logic [1:0] player_code(input logic p);
      return (p == PLAYER_CIR) ? CELL_CIR : CELL_TRI;
   endfunction

endpackage

// File: rtl/run_length_counter.sv
// Counts consecutive matching samples; hit flags a run of at least WIN_LEN.
// clear discards the previous run, so clear+enable starts a fresh run with this sample.
module run_length_counter
   import game_pkg::*;
#(
   parameter int WIN_LEN = DEFAULT_WIN_LEN,
   parameter int RUN_W   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic             match,
   output logic [RUN_W-1:0] run,
   output logic             hit
);

   localparam logic [RUN_W-1:0] WIN_L = RUN_W'(WIN_LEN);

   logic [RUN_W-1:0] run_q, run_d, base;

   always_comb begin
      base  = clear ? '0 : run_q;
      run_d = base;
      if (enable) begin
         if (!match)
            run_d = '0;
         else if (base != '1)
            run_d = base + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         run_q <= '0;
      else
         run_q <= run_d;
   end

   assign run = run_q;
   assign hit = (run_q >= WIN_L);

endmodule

// File: rtl/turn_controller.sv
// Two-player game sequencer: validates moves, commits them, scans row/column for a win.
// Define TURN_TIMEOUT_EN to forfeit a turn after TIMEOUT_CYCLES idle WAIT cycles.
module turn_controller
   import game_pkg::*;
#(
   parameter int GRID           = DEFAULT_GRID,
   parameter int WIN_LEN        = DEFAULT_WIN_LEN,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       coord_valid,
   input  logic [3:0] x_in,
   input  logic [3:0] y_in,
   input  logic [3:0] rd_x,
   input  logic [3:0] rd_y,
   output logic [1:0] rd_cell,
   output logic [2:0] ctrl_state,
   output logic       active_player,
   output logic       move_accept,
   output logic       move_reject,
   output logic [6:0] tri_moves,
   output logic [6:0] cir_moves,
   output logic       game_over,
   output logic [1:0] winner,
   output logic       turn_timeout
);

   localparam logic [4:0] GRID_W   = 5'(GRID);
   localparam logic [3:0] LAST_IDX = 4'(GRID - 1);
   localparam logic [8:0] CELLS    = 9'(GRID * GRID);
   localparam logic [6:0] CNT_MAX  = (GRID * GRID > 127) ? 7'd127 : 7'(GRID * GRID);

   state_e     state_q, state_d;
   logic       player_q, player_d;
   logic [3:0] x_q, x_d, y_q, y_d, idx_q, idx_d;
   logic       win_q, win_d;
   logic [1:0] winner_q, winner_d;
   logic [6:0] tri_q, tri_d, cir_q, cir_d;
   logic       accept_q, accept_d, reject_q, reject_d;
   logic       wr_en, clr_board, run_clear, run_en, run_match, run_hit;
   logic       to_fire;
   logic       cell_free;
   logic [1:0] scan_cell;
   logic [8:0] total_moves;

   // Board addressed as {y,x}; cells beyond GRID are never written and stay empty.
   logic [1:0] board_q [256];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 256; i++) board_q[i] <= CELL_EMPTY;
      end else if (clr_board) begin
         for (int i = 0; i < 256; i++) board_q[i] <= CELL_EMPTY;
      end else if (wr_en) begin
         board_q[{y_q, x_q}] <= player_code(player_q);
      end
   end

   assign rd_cell = ({1'b0, rd_x} < GRID_W && {1'b0, rd_y} < GRID_W) ?
                    board_q[{rd_y, rd_x}] : CELL_EMPTY;
   assign cell_free = ({1'b0, x_q} < GRID_W) && ({1'b0, y_q} < GRID_W) &&
                      (board_q[{y_q, x_q}] == CELL_EMPTY);
   assign scan_cell = (state_q == ST_SCAN_ROW) ? board_q[{y_q, idx_q}] : board_q[{idx_q, x_q}];
   assign run_match = (scan_cell == player_code(player_q));
   assign total_moves = {2'b00, tri_q} + {2'b00, cir_q};

   run_length_counter #(.WIN_LEN(WIN_LEN), .RUN_W(5)) u_run (
      .clk    (clk),
      .reset  (reset),
      .clear  (run_clear),
      .enable (run_en),
      .match  (run_match),
      .run    (),
      .hit    (run_hit)
   );

`ifdef TURN_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] to_cnt_q;

   assign to_fire = (state_q == ST_WAIT) && !coord_valid && (to_cnt_q == TO_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         to_cnt_q <= '0;
      else if (state_q != ST_WAIT || coord_valid || to_fire)
         to_cnt_q <= '0;
      else
         to_cnt_q <= to_cnt_q + 1'b1;
   end
   assign turn_timeout = to_fire;
`else
   assign to_fire      = 1'b0;
   assign turn_timeout = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      player_d  = player_q;
      x_d       = x_q;
      y_d       = y_q;
      idx_d     = idx_q;
      win_d     = win_q;
      winner_d  = winner_q;
      tri_d     = tri_q;
      cir_d     = cir_q;
      accept_d  = 1'b0;
      reject_d  = 1'b0;
      wr_en     = 1'b0;
      clr_board = 1'b0;
      run_clear = 1'b0;
      run_en    = 1'b0;
      case (state_q)
         ST_IDLE, ST_GAME_OVER: begin
            if (start) begin
               clr_board = 1'b1;
               tri_d     = '0;
               cir_d     = '0;
               winner_d  = WIN_NONE;
               player_d  = PLAYER_TRI;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (coord_valid) begin
               x_d     = x_in;
               y_d     = y_in;
               state_d = ST_CHECK;
            end else if (to_fire) begin
               player_d = ~player_q;
            end
         end
         ST_CHECK: begin
            if (cell_free) begin
               wr_en    = 1'b1;
               accept_d = 1'b1;
               win_d    = 1'b0;
               idx_d    = '0;
               state_d  = ST_SCAN_ROW;
               if (player_q == PLAYER_CIR)
                  cir_d = (cir_q == CNT_MAX) ? cir_q : cir_q + 1'b1;
               else
                  tri_d = (tri_q == CNT_MAX) ? tri_q : tri_q + 1'b1;
            end else begin
               reject_d = 1'b1;
               state_d  = ST_WAIT;
            end
         end
         // The counter's output lags one sample, so index 0 still shows the previous run.
         ST_SCAN_ROW: begin
            run_en    = 1'b1;
            run_clear = (idx_q == 4'd0);
            if (idx_q != 4'd0 && run_hit) win_d = 1'b1;
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = ST_SCAN_COL;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_SCAN_COL: begin
            run_en    = 1'b1;
            run_clear = (idx_q == 4'd0);
            if (run_hit) win_d = 1'b1;
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = ST_DECIDE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DECIDE: begin
            if (win_q || run_hit) begin
               winner_d = player_code(player_q);
               state_d  = ST_GAME_OVER;
            end else if (total_moves == CELLS) begin
               winner_d = WIN_DRAW;
               state_d  = ST_GAME_OVER;
            end else begin
               player_d = ~player_q;
               state_d  = ST_WAIT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         player_q <= PLAYER_TRI;
         x_q      <= '0;
         y_q      <= '0;
         idx_q    <= '0;
         win_q    <= 1'b0;
         winner_q <= WIN_NONE;
         tri_q    <= '0;
         cir_q    <= '0;
         accept_q <= 1'b0;
         reject_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         player_q <= player_d;
         x_q      <= x_d;
         y_q      <= y_d;
         idx_q    <= idx_d;
         win_q    <= win_d;
         winner_q <= winner_d;
         tri_q    <= tri_d;
         cir_q    <= cir_d;
         accept_q <= accept_d;
         reject_q <= reject_d;
      end
   end

   assign ctrl_state    = state_q;
   assign active_player = player_q;
   assign move_accept   = accept_q;
   assign move_reject   = reject_q;
   assign tri_moves     = tri_q;
   assign cir_moves     = cir_q;
   assign game_over     = (state_q == ST_GAME_OVER);
   assign winner        = winner_q;

endmodule

// File: tb/tb_turn_controller.sv
// Self-checking bench for turn_controller: directed games plus random stimulus,
// compared every cycle against a move-level model of the game rules.
module tb_turn_controller;

   localparam int G = 10;
   localparam int W = 4;

   logic       clk, rst_n, start, coord_valid;
   logic [3:0] x_in, y_in, rd_x, rd_y;
   logic [1:0] rd_cell, winner;
   logic [2:0] ctrl_state;
   logic       active_player, move_accept, move_reject, game_over, turn_timeout;
   logic [6:0] tri_moves, cir_moves;

   turn_controller #(.GRID(G), .WIN_LEN(W), .TIMEOUT_CYCLES(1000)) dut (
      .clk           (clk),
      .reset         (rst_n),
      .start         (start),
      .coord_valid   (coord_valid),
      .x_in          (x_in),
      .y_in          (y_in),
      .rd_x          (rd_x),
      .rd_y          (rd_y),
      .rd_cell       (rd_cell),
      .ctrl_state    (ctrl_state),
      .active_player (active_player),
      .move_accept   (move_accept),
      .move_reject   (move_reject),
      .tri_moves     (tri_moves),
      .cir_moves     (cir_moves),
      .game_over     (game_over),
      .winner        (winner),
      .turn_timeout  (turn_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;

   // Move-level model: 0 idle, 1 wait, 2 check, 3 busy (m_e cycles since commit), 6 over.
   int         m_st, m_e, m_x, m_y, m_tri, m_cir;
   logic       m_player, m_win, m_accept, m_reject;
   logic [1:0] m_winner;
   logic [1:0] m_board [G][G];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int longest_run(input logic [1:0] code, input bit along_row, input int fixed);
      int best = 0;
      int cur = 0;
      for (int i = 0; i < G; i++) begin
         logic [1:0] c;
         c = along_row ? m_board[fixed][i] : m_board[i][fixed];
         cur = (c == code) ? cur + 1 : 0;
         if (cur > best) best = cur;
      end
      return best;
   endfunction

   task automatic model_reset();
      m_st = 0; m_e = 0; m_player = 1'b0; m_tri = 0; m_cir = 0;
      m_winner = 2'b00; m_accept = 1'b0; m_reject = 1'b0; m_win = 1'b0;
      for (int y = 0; y < G; y++)
         for (int x = 0; x < G; x++) m_board[y][x] = 2'b00;
   endtask

   task automatic model_step();
      logic [1:0] code;
      code = m_player ? 2'b10 : 2'b01;
      m_accept = 1'b0;
      m_reject = 1'b0;
      if (m_st == 0 || m_st == 6) begin
         if (start) begin
            for (int y = 0; y < G; y++)
               for (int x = 0; x < G; x++) m_board[y][x] = 2'b00;
            m_tri = 0; m_cir = 0; m_winner = 2'b00; m_player = 1'b0; m_st = 1;
         end
      end else if (m_st == 1) begin
         if (coord_valid) begin
            m_x = int'(x_in); m_y = int'(y_in); m_st = 2;
         end
      end else if (m_st == 2) begin
         bit legal;
         legal = 1'b0;
         if (m_x < G && m_y < G) legal = (m_board[m_y][m_x] == 2'b00);
         if (legal) begin
            m_board[m_y][m_x] = code;
            if (m_player) m_cir++; else m_tri++;
            m_win = (longest_run(code, 1'b1, m_y) >= W) || (longest_run(code, 1'b0, m_x) >= W);
            m_accept = 1'b1; m_e = 0; m_st = 3;
         end else begin
            m_reject = 1'b1; m_st = 1;
         end
      end else begin
         m_e++;
         if (m_e == 2 * G + 1) begin
            if (m_win) begin
               m_winner = code; m_st = 6;
            end else if (m_tri + m_cir == G * G) begin
               m_winner = 2'b11; m_st = 6;
            end else begin
               m_player = ~m_player; m_st = 1;
            end
         end
      end
   endtask

   function automatic int exp_state();
      if (m_st != 3) return m_st;
      if (m_e < G) return 3;
      if (m_e < 2 * G) return 4;
      return 5;
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         chk("ctrl_state", 32'(ctrl_state), 32'(exp_state()));
         chk("active_player", 32'(active_player), 32'(m_player));
         chk("move_accept", 32'(move_accept), 32'(m_accept));
         chk("move_reject", 32'(move_reject), 32'(m_reject));
         chk("tri_moves", 32'(tri_moves), 32'(m_tri));
         chk("cir_moves", 32'(cir_moves), 32'(m_cir));
         chk("game_over", 32'(game_over), 32'(m_st == 6));
         chk("winner", 32'(winner), 32'(m_winner));
         chk("turn_timeout", 32'(turn_timeout), 32'd0);
         chk("rd_cell", 32'(rd_cell),
             (rd_x < G && rd_y < G) ? 32'(m_board[rd_y][rd_x]) : 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      start       = 1'b0;
      coord_valid = 1'b0;
      rd_x        = 4'($urandom_range(0, 15));
      rd_y        = 4'($urandom_range(0, 15));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
   endtask

   task automatic play(input int x, input int y);
      int n;
      n = 0;
      while (m_st != 1 && n < 300) begin tick(); n++; end
      if (n >= 300) begin
         n_checks++; n_errors++;
         $display("FAIL play_wait: WAIT not reached within %0d cycles, required <300", n);
      end
      coord_valid = 1'b1; x_in = 4'(x); y_in = 4'(y);
      tick();
      n = 0;
      do begin tick(); n++; end while (m_st != 1 && m_st != 6 && n < 300);
   endtask

   initial begin
      int tx[$], ty[$], cx[$], cy[$];
      rst_n = 1'b0; start = 1'b0; coord_valid = 1'b0;
      x_in = '0; y_in = '0; rd_x = '0; rd_y = '0;
      do_reset();
      repeat (3) tick();
      @(negedge clk);
      chk("lit_reset_state", 32'(ctrl_state), 32'd0);
      chk("lit_reset_winner", 32'(winner), 32'd0);
      tick();
      rst_n = 1'b1;

      // First triangle move at (2,3)
      start = 1'b1;
      tick();
      coord_valid = 1'b1; x_in = 4'd2; y_in = 4'd3;
      tick();
      tick();
      rd_x = 4'd2; rd_y = 4'd3;
      @(negedge clk);
      chk("lit_accept", 32'(move_accept), 32'd1);
      chk("lit_rd_cell_2_3", 32'(rd_cell), 32'd1);
      chk("lit_tri_moves", 32'(tri_moves), 32'd1);
      repeat (21) tick();
      @(negedge clk);
      chk("lit_player_after", 32'(active_player), 32'd1);
      chk("lit_state_wait", 32'(ctrl_state), 32'd1);

      // Circle on the occupied cell, then two out-of-range coordinates
      coord_valid = 1'b1; x_in = 4'd2; y_in = 4'd3;
      tick(); tick();
      @(negedge clk);
      chk("lit_reject_occupied", 32'(move_reject), 32'd1);
      chk("lit_cir_zero", 32'(cir_moves), 32'd0);
      chk("lit_player_kept", 32'(active_player), 32'd1);
      coord_valid = 1'b1; x_in = 4'd10; y_in = 4'd5;
      tick(); tick();
      @(negedge clk);
      chk("lit_reject_x10", 32'(move_reject), 32'd1);
      coord_valid = 1'b1; x_in = 4'd5; y_in = 4'd12;
      tick(); tick();
      @(negedge clk);
      chk("lit_reject_y12", 32'(move_reject), 32'd1);

      // Triangle completes row 0
      play(9, 9);
      play(0, 0); play(0, 5); play(1, 0); play(1, 5); play(2, 0); play(2, 5); play(3, 0);
      @(negedge clk);
      chk("lit_winner_tri", 32'(winner), 32'd1);
      chk("lit_game_over", 32'(game_over), 32'd1);
      coord_valid = 1'b1; x_in = 4'd5; y_in = 4'd5;
      tick(); tick();
      @(negedge clk);
      chk("lit_ignored_in_over", 32'(tri_moves), 32'd5);
      start = 1'b1;
      tick();
      rd_x = 4'd0; rd_y = 4'd0;
      @(negedge clk);
      chk("lit_restart_state", 32'(ctrl_state), 32'd1);
      chk("lit_restart_cleared", 32'(rd_cell), 32'd0);
      chk("lit_restart_player", 32'(active_player), 32'd0);

      // Full board without any run of 4: pairs alternate along rows, cells alternate down columns
      for (int y = 0; y < G; y++)
         for (int x = 0; x < G; x++)
            if ((((x >> 1) + y) & 1) == 0) begin tx.push_back(x); ty.push_back(y); end
            else begin cx.push_back(x); cy.push_back(y); end
      for (int i = 0; i < 50; i++) begin
         play(tx[i], ty[i]);
         play(cx[i], cy[i]);
      end
      @(negedge clk);
      chk("lit_draw", 32'(winner), 32'd3);
      chk("lit_draw_cir", 32'(cir_moves), 32'd50);

      // Reset in the middle of a row scan
      start = 1'b1;
      tick();
      coord_valid = 1'b1; x_in = 4'd4; y_in = 4'd4;
      tick();
      repeat (4) tick();
      do_reset();
      rd_x = 4'd4; rd_y = 4'd4;
      @(negedge clk);
      chk("lit_midscan_state", 32'(ctrl_state), 32'd0);
      chk("lit_midscan_tri", 32'(tri_moves), 32'd0);
      chk("lit_midscan_cell", 32'(rd_cell), 32'd0);
      tick();
      rst_n = 1'b1;

      // Random play, with stray starts, coordinates outside WAIT and rare resets
      for (int c = 0; c < 9000; c++) begin
         if ($urandom_range(0, 2999) == 0) begin
            do_reset();
            tick();
            rst_n = 1'b1;
         end
         start       = ($urandom_range(0, 39) == 0);
         coord_valid = ($urandom_range(0, 2) == 0);
         x_in        = 4'($urandom_range(0, 11));
         y_in        = 4'($urandom_range(0, 11));
         tick();
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
